// File: rtl/lifo_register_stack.sv
// lifo_register_stack: bounded LIFO of WIDTH-bit registers.
// Supports push, pop, replace-top (push+pop) and synchronous clear.
// Status outputs are count/empty/full, plus a sticky overflow/underflow error flag.
//
// Handshake: push and pop are single-cycle strobes sampled on the rising edge.
// There is no ready/backpressure. A push into a full stack is dropped, as is a
// pop from an empty stack, and either one raises err. A request that is not
// rejected completes on the edge where it is sampled. q is valid whenever
// empty is low.
module lifo_register_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err
);

  // Entry index width. Any live index is strictly below DEPTH, so it fits in AW bits.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic [AW-1:0]    wr_idx;   // slot above the top (valid only when not full)
  logic [AW-1:0]    top_idx;  // current top slot (valid only when not empty)
  logic [AW-1:0]    rd_idx;   // top_idx, forced to 0 when empty so reads stay in range
  logic             is_empty;
  logic             is_full;

  // Status decodes and index arithmetic from the registered count.
  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == CW'(DEPTH));
    wr_idx   = AW'(count_q);
    top_idx  = AW'(count_q - CW'(1));
    rd_idx   = is_empty ? '0 : top_idx;
  end

  // Next-state: clr > push-only > pop-only > push+pop (replace) > hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    count_d = count_q;
    err_d   = err_q;
    if (clr) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if (push && !pop) begin
      if (!is_full) begin
        mem_d[wr_idx] = d;
        count_d       = count_q + CW'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (!push && pop) begin
      if (!is_empty) begin
        count_d = count_q - CW'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (push && pop) begin
      if (!is_empty) begin
        mem_d[top_idx] = d;
      end else begin
        // Replace on an empty stack behaves as a push but flags the underflow.
        mem_d[wr_idx] = d;
        count_d       = CW'(1);
        err_d         = 1'b1;
      end
    end
  end

  // State registers; asynchronous reset clears everything, including storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Outputs are pure decodes of registered state; the stale slots above the top are never shown.
  always_comb begin
    q     = is_empty ? '0 : mem_q[rd_idx];
    count = count_q;
    empty = is_empty;
    full  = is_full;
    err   = err_q;
  end

endmodule

// File: tb/tb_lifo_register_stack.sv
// Directed bench for lifo_register_stack.
// Instance a is the default 12-bit x 8 stack; instance b is the 8-bit x 5 odd-depth stack.
module tb_lifo_register_stack;

  logic        clk;
  logic        rst;

  logic        clr_a, push_a, pop_a;
  logic [11:0] d_a, q_a;
  logic [3:0]  count_a;
  logic        empty_a, full_a, err_a;

  logic        clr_b, push_b, pop_b;
  logic [7:0]  d_b, q_b;
  logic [2:0]  count_b;
  logic        empty_b, full_b, err_b;

  int checks;
  int failures;

  lifo_register_stack #(.WIDTH(12), .DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .clr(clr_a), .push(push_a), .pop(pop_a), .d(d_a),
    .q(q_a), .count(count_a), .empty(empty_a), .full(full_a), .err(err_a)
  );

  lifo_register_stack #(.WIDTH(8), .DEPTH(5)) dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .push(push_b), .pop(pop_b), .d(d_b),
    .q(q_b), .count(count_b), .empty(empty_b), .full(full_b), .err(err_b)
  );

  // Clock: 10 time-unit period, first rising edge at t=5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One edge of instance-a activity, with inputs driven 1 unit after the previous edge.
  task automatic op_a(input logic c, input logic pu, input logic po, input logic [11:0] dv);
    clr_a = c; push_a = pu; pop_a = po; d_a = dv;
    @(posedge clk); #1;
    clr_a = 1'b0; push_a = 1'b0; pop_a = 1'b0;
  endtask

  // Pop on instance a while checking q in the pop cycle (sampled on the falling edge).
  task automatic pop_check_a(input logic [11:0] exp);
    pop_a = 1'b1;
    @(negedge clk);
    chk("a_pop_q", q_a, exp);
    @(posedge clk); #1;
    pop_a = 1'b0;
  endtask

  task automatic op_b(input logic c, input logic pu, input logic po, input logic [7:0] dv);
    clr_b = c; push_b = pu; pop_b = po; d_b = dv;
    @(posedge clk); #1;
    clr_b = 1'b0; push_b = 1'b0; pop_b = 1'b0;
  endtask

  task automatic pop_check_b(input logic [7:0] exp);
    pop_b = 1'b1;
    @(negedge clk);
    chk("b_pop_q", q_b, exp);
    chk("b_count_le_depth", (count_b <= 3'd5), 1);
    @(posedge clk); #1;
    pop_b = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    clr_a = 0; push_a = 0; pop_a = 0; d_a = '0;
    clr_b = 0; push_b = 0; pop_b = 0; d_b = '0;

    // Power-on reset state.
    #1;
    chk("rst_q", q_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_err", err_a, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset asserted mid-cycle with three entries stacked.
    op_a(0, 1, 0, 12'h00A);
    op_a(0, 1, 0, 12'h00B);
    op_a(0, 1, 0, 12'h00C);
    chk("pre_rst_count", count_a, 3);
    chk("pre_rst_q", q_a, 12'h00C);
    #2; rst = 1'b1; #1;
    chk("mid_rst_q", q_a, 0);
    chk("mid_rst_count", count_a, 0);
    chk("mid_rst_empty", empty_a, 1);
    chk("mid_rst_full", full_a, 0);
    chk("mid_rst_err", err_a, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Fill with 0x001..0x008 on consecutive edges.
    for (int i = 1; i <= 8; i++) begin
      op_a(0, 1, 0, 12'(i));
    end
    chk("fill_full", full_a, 1);
    chk("fill_count", count_a, 8);
    chk("fill_q", q_a, 12'h008);
    chk("fill_err", err_a, 0);

    // Overflow: rejected push, sticky error.
    op_a(0, 1, 0, 12'hABC);
    chk("ovf_count", count_a, 8);
    chk("ovf_q", q_a, 12'h008);
    chk("ovf_err", err_a, 1);

    // Drain: back-to-back pops read 0x008 down to 0x001.
    for (int i = 8; i >= 1; i--) begin
      pop_check_a(12'(i));
    end
    chk("drain_empty", empty_a, 1);
    chk("drain_q", q_a, 0);
    chk("drain_err_sticky", err_a, 1);

    // Clear, then underflow.
    op_a(1, 0, 0, 12'h000);
    chk("clr_err", err_a, 0);
    chk("clr_empty", empty_a, 1);
    op_a(0, 0, 1, 12'h000);
    chk("udf_count", count_a, 0);
    chk("udf_err", err_a, 1);
    op_a(1, 0, 0, 12'h000);

    // Replace top.
    op_a(0, 1, 0, 12'h111);
    op_a(0, 1, 0, 12'h222);
    op_a(0, 1, 1, 12'h333);
    chk("rep_count", count_a, 2);
    chk("rep_q", q_a, 12'h333);
    chk("rep_err", err_a, 0);
    pop_check_a(12'h333);
    chk("rep_pop_q", q_a, 12'h111);
    pop_check_a(12'h111);
    chk("rep_drain_empty", empty_a, 1);

    // Replace on an empty stack acts as push with error.
    op_a(0, 1, 1, 12'h044);
    chk("rep_empty_count", count_a, 1);
    chk("rep_empty_q", q_a, 12'h044);
    chk("rep_empty_err", err_a, 1);

    // Replace when full: no error raised.
    op_a(1, 0, 0, 12'h000);
    for (int i = 0; i < 8; i++) begin
      op_a(0, 1, 0, 12'h100 + 12'(i));
    end
    op_a(0, 1, 1, 12'h5A5);
    chk("rep_full_count", count_a, 8);
    chk("rep_full_q", q_a, 12'h5A5);
    chk("rep_full_err", err_a, 0);

    // Priority: clr wins over push+pop with count=5 and err=1.
    op_a(1, 0, 0, 12'h000);
    op_a(0, 0, 1, 12'h000);
    for (int i = 0; i < 5; i++) begin
      op_a(0, 1, 0, 12'h700 + 12'(i));
    end
    chk("prio_pre_count", count_a, 5);
    chk("prio_pre_err", err_a, 1);
    op_a(1, 1, 1, 12'hFFF);
    chk("prio_count", count_a, 0);
    chk("prio_err", err_a, 0);
    chk("prio_q", q_a, 0);

    // Odd depth: five pushes fill, the sixth is rejected.
    for (int i = 0; i < 5; i++) begin
      op_b(0, 1, 0, 8'h10 + 8'(i));
      chk("b_fill_count", count_b, i + 1);
      chk("b_fill_full", full_b, (i == 4) ? 1 : 0);
    end
    chk("b_fill_err", err_b, 0);
    op_b(0, 1, 0, 8'h15);
    chk("b_ovf_err", err_b, 1);
    chk("b_ovf_count", count_b, 5);
    chk("b_ovf_q", q_b, 8'h14);
    for (int i = 0; i < 5; i++) begin
      pop_check_b(8'h14 - 8'(i));
    end
    chk("b_drain_empty", empty_b, 1);
    chk("b_drain_q", q_b, 0);
    chk("b_drain_count", count_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
